// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-state control unit for the Datapath.
// Steps RESET -> T0..T7 -> T0/HALTED, decoding IR[31:27] in T3.
// Outputs are Moore-decoded from the state register (plus IR/CON) and
// wire 1:1 to the same-named Datapath inputs.
// Optional feature macro: CU_MULDIV_EN (decode mul/div and drive HI/LO loads).
// Handshake: none; one datapath micro-step is taken on every rising clk edge.
module control_sequencer #(
    parameter int             OPW    = 5,
    parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [31:0]    IR,
    input  logic           CON,
    input  logic           stop,
    output logic           PC_out,
    output logic           ZLow_out,
    output logic           ZHigh_out,
    output logic           HI_out,
    output logic           LO_out,
    output logic           C_out,
    output logic           In_port_out,
    output logic           MDR_out,
    output logic           MAR_enable,
    output logic           Z_enable,
    output logic           PC_enable,
    output logic           MDR_enable,
    output logic           IR_enable,
    output logic           Y_enable,
    output logic           HI_enable,
    output logic           LO_enable,
    output logic           IncPC,
    output logic           Read,
    output logic           RAM_write_enable,
    output logic           con_in,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           R_in,
    output logic           R_out,
    output logic           BA_out,
    output logic [OPW-1:0] opcode,
    output logic           run,
    output logic [3:0]     state_dbg
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_T7     = 4'd8,
        S_HALTED = 4'd9
    } state_t;

    state_t     state;
    state_t     end_next;
    logic [4:0] op;
    logic       is_alu_reg, is_alu_imm, is_ldi, is_ld, is_st;
    logic       is_br, is_jr, is_halt, is_md, is_exec;
    logic [4:0] imm_alu_op;
    logic       unused_ir_bits;

    assign op             = IR[31:27];
    assign unused_ir_bits = ^IR[26:0];
    assign state_dbg      = state;

    // Instruction class decode from the opcode field
    assign is_alu_reg = (op >= 5'b00011) && (op <= 5'b01011);
    assign is_alu_imm = (op >= 5'b01100) && (op <= 5'b01110);
    assign is_ldi     = (op == 5'b00001);
    assign is_ld      = (op == 5'b00000);
    assign is_st      = (op == 5'b00010);
    assign is_br      = (op == 5'b10011);
    assign is_jr      = (op == 5'b10100);
    assign is_halt    = (op == 5'b11011);
`ifdef CU_MULDIV_EN
    assign is_md      = (op == 5'b01111) || (op == 5'b10000);
`else
    assign is_md      = 1'b0;
`endif
    assign is_exec = is_alu_reg | is_alu_imm | is_ldi | is_ld | is_st
                   | is_br | is_jr | is_md;

    // addi/andi/ori map onto the add/and/or ALU operations
    assign imm_alu_op = (op == 5'b01100) ? 5'b00011 :
                        (op == 5'b01101) ? 5'b01010 : 5'b01011;

    // Where the last step of an instruction goes
    assign end_next = stop ? S_HALTED : S_T0;

    // State register: clr wins from any state, otherwise step the T-states
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET:  state <= S_T0;
                S_T0:     state <= S_T1;
                S_T1:     state <= S_T2;
                S_T2: begin
                    if (is_halt)       state <= S_HALTED;
                    else if (is_exec)  state <= S_T3;
                    else               state <= end_next;
                end
                S_T3:     state <= is_jr ? end_next : S_T4;
                S_T4:     state <= S_T5;
                S_T5:     state <= (is_ld | is_st | is_br | is_md) ? S_T6 : end_next;
                S_T6:     state <= (is_ld | is_st) ? S_T7 : end_next;
                S_T7:     state <= end_next;
                S_HALTED: state <= S_HALTED;
                default:  state <= S_RESET;
            endcase
        end
    end

    // Control word decode from the current state and instruction class
    always_comb begin
        PC_out = 1'b0; ZLow_out = 1'b0; ZHigh_out = 1'b0; HI_out = 1'b0;
        LO_out = 1'b0; C_out = 1'b0; In_port_out = 1'b0; MDR_out = 1'b0;
        MAR_enable = 1'b0; Z_enable = 1'b0; PC_enable = 1'b0; MDR_enable = 1'b0;
        IR_enable = 1'b0; Y_enable = 1'b0; HI_enable = 1'b0; LO_enable = 1'b0;
        IncPC = 1'b0; Read = 1'b0; RAM_write_enable = 1'b0; con_in = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; R_in = 1'b0; R_out = 1'b0;
        BA_out = 1'b0;
        opcode = '0;
        run = (state != S_HALTED);
        case (state)
            S_T0: begin
                PC_out = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; PC_enable = 1'b1;
            end
            S_T1: begin
                Read = 1'b1; MDR_enable = 1'b1;
            end
            S_T2: begin
                MDR_out = 1'b1; IR_enable = 1'b1;
            end
            S_T3: begin
                if (is_alu_reg | is_alu_imm) begin
                    Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1;
                end else if (is_ldi | is_ld | is_st) begin
                    Grb = 1'b1; BA_out = 1'b1; Y_enable = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; R_out = 1'b1; con_in = 1'b1;
                end else if (is_jr) begin
                    Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1;
                end else if (is_md) begin
                    Gra = 1'b1; R_out = 1'b1; Y_enable = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu_reg) begin
                    Grc = 1'b1; R_out = 1'b1; Z_enable = 1'b1; opcode = OPW'(op);
                end else if (is_alu_imm) begin
                    C_out = 1'b1; Z_enable = 1'b1; opcode = OPW'(imm_alu_op);
                end else if (is_ldi | is_ld | is_st) begin
                    C_out = 1'b1; Z_enable = 1'b1; opcode = ADD_OP;
                end else if (is_br) begin
                    PC_out = 1'b1; Y_enable = 1'b1;
                end else if (is_md) begin
                    Grb = 1'b1; R_out = 1'b1; Z_enable = 1'b1; opcode = OPW'(op);
                end
            end
            S_T5: begin
                if (is_alu_reg | is_alu_imm | is_ldi) begin
                    ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
                end else if (is_ld | is_st) begin
                    ZLow_out = 1'b1; MAR_enable = 1'b1;
                end else if (is_br) begin
                    C_out = 1'b1; Z_enable = 1'b1; opcode = ADD_OP;
                end else if (is_md) begin
                    ZLow_out = 1'b1; LO_enable = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    Read = 1'b1; MDR_enable = 1'b1;
                end else if (is_st) begin
                    // Read stays low so the MDR loads from the bus
                    Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1;
                end else if (is_br) begin
                    ZLow_out = 1'b1; PC_enable = CON;
                end else if (is_md) begin
                    ZHigh_out = 1'b1; HI_enable = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDR_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
                end else if (is_st) begin
                    RAM_write_enable = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized checks of control_sequencer.
// A per-instruction micro-step table model fills exp_q with the expected
// control word for every clock, which is compared against the DUT outputs.
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [31:0] IR;
  logic        CON;
  logic        stop;
  logic        PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out, MDR_out;
  logic        MAR_enable, Z_enable, PC_enable, MDR_enable, IR_enable, Y_enable;
  logic        HI_enable, LO_enable;
  logic        IncPC, Read, RAM_write_enable, con_in, Gra, Grb, Grc, R_in, R_out, BA_out;
  logic [4:0]  opcode;
  logic        run;
  logic [3:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // Control word bit positions: {run, opcode[4:0], 26 single-bit controls}
  localparam logic [31:0] M_PC_OUT  = 32'd1 << 0;
  localparam logic [31:0] M_ZLOW    = 32'd1 << 1;
  localparam logic [31:0] M_ZHIGH   = 32'd1 << 2;
  localparam logic [31:0] M_C_OUT   = 32'd1 << 5;
  localparam logic [31:0] M_MDR_OUT = 32'd1 << 7;
  localparam logic [31:0] M_MAR_EN  = 32'd1 << 8;
  localparam logic [31:0] M_Z_EN    = 32'd1 << 9;
  localparam logic [31:0] M_PC_EN   = 32'd1 << 10;
  localparam logic [31:0] M_MDR_EN  = 32'd1 << 11;
  localparam logic [31:0] M_IR_EN   = 32'd1 << 12;
  localparam logic [31:0] M_Y_EN    = 32'd1 << 13;
  localparam logic [31:0] M_HI_EN   = 32'd1 << 14;
  localparam logic [31:0] M_LO_EN   = 32'd1 << 15;
  localparam logic [31:0] M_INCPC   = 32'd1 << 16;
  localparam logic [31:0] M_READ    = 32'd1 << 17;
  localparam logic [31:0] M_RAM_WE  = 32'd1 << 18;
  localparam logic [31:0] M_CON_IN  = 32'd1 << 19;
  localparam logic [31:0] M_GRA     = 32'd1 << 20;
  localparam logic [31:0] M_GRB     = 32'd1 << 21;
  localparam logic [31:0] M_GRC     = 32'd1 << 22;
  localparam logic [31:0] M_R_IN    = 32'd1 << 23;
  localparam logic [31:0] M_R_OUT   = 32'd1 << 24;
  localparam logic [31:0] M_BA_OUT  = 32'd1 << 25;
  localparam logic [31:0] M_RUN     = 32'd1 << 31;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .CON(CON), .stop(stop),
    .PC_out(PC_out), .ZLow_out(ZLow_out), .ZHigh_out(ZHigh_out), .HI_out(HI_out),
    .LO_out(LO_out), .C_out(C_out), .In_port_out(In_port_out), .MDR_out(MDR_out),
    .MAR_enable(MAR_enable), .Z_enable(Z_enable), .PC_enable(PC_enable),
    .MDR_enable(MDR_enable), .IR_enable(IR_enable), .Y_enable(Y_enable),
    .HI_enable(HI_enable), .LO_enable(LO_enable), .IncPC(IncPC), .Read(Read),
    .RAM_write_enable(RAM_write_enable), .con_in(con_in), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .R_in(R_in), .R_out(R_out), .BA_out(BA_out), .opcode(opcode),
    .run(run), .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] opw(input logic [4:0] o);
    return {1'b0, o, 26'd0};
  endfunction

  function automatic logic [31:0] observed();
    return {run, opcode, BA_out, R_out, R_in, Grc, Grb, Gra, con_in, RAM_write_enable,
            Read, IncPC, LO_enable, HI_enable, Y_enable, IR_enable, MDR_enable,
            PC_enable, Z_enable, MAR_enable, MDR_out, In_port_out, C_out, LO_out,
            HI_out, ZHigh_out, ZLow_out, PC_out};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: one control word per clock for the whole instruction.
  // Returns 1 when the instruction itself halts the machine.
  function automatic bit model_instr(input logic [31:0] ir, input logic con);
    logic [4:0] op;
    logic [4:0] imm_op;
    op = ir[31:27];
    exp_q.push_back(M_RUN | M_PC_OUT | M_MAR_EN | M_INCPC | M_PC_EN);
    exp_q.push_back(M_RUN | M_READ | M_MDR_EN);
    exp_q.push_back(M_RUN | M_MDR_OUT | M_IR_EN);
    if (op >= 5'd3 && op <= 5'd11) begin
      exp_q.push_back(M_RUN | M_GRB | M_R_OUT | M_Y_EN);
      exp_q.push_back(M_RUN | M_GRC | M_R_OUT | M_Z_EN | opw(op));
      exp_q.push_back(M_RUN | M_ZLOW | M_GRA | M_R_IN);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      imm_op = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd10 : 5'd11;
      exp_q.push_back(M_RUN | M_GRB | M_R_OUT | M_Y_EN);
      exp_q.push_back(M_RUN | M_C_OUT | M_Z_EN | opw(imm_op));
      exp_q.push_back(M_RUN | M_ZLOW | M_GRA | M_R_IN);
    end else if (op <= 5'd2) begin
      exp_q.push_back(M_RUN | M_GRB | M_BA_OUT | M_Y_EN);
      exp_q.push_back(M_RUN | M_C_OUT | M_Z_EN | opw(5'd3));
      if (op == 5'd1) begin
        exp_q.push_back(M_RUN | M_ZLOW | M_GRA | M_R_IN);
      end else begin
        exp_q.push_back(M_RUN | M_ZLOW | M_MAR_EN);
        if (op == 5'd0) begin
          exp_q.push_back(M_RUN | M_READ | M_MDR_EN);
          exp_q.push_back(M_RUN | M_MDR_OUT | M_GRA | M_R_IN);
        end else begin
          exp_q.push_back(M_RUN | M_GRA | M_R_OUT | M_MDR_EN);
          exp_q.push_back(M_RUN | M_RAM_WE);
        end
      end
    end else if (op == 5'd19) begin
      exp_q.push_back(M_RUN | M_GRA | M_R_OUT | M_CON_IN);
      exp_q.push_back(M_RUN | M_PC_OUT | M_Y_EN);
      exp_q.push_back(M_RUN | M_C_OUT | M_Z_EN | opw(5'd3));
      exp_q.push_back(M_RUN | M_ZLOW | (con ? M_PC_EN : 32'd0));
    end else if (op == 5'd20) begin
      exp_q.push_back(M_RUN | M_GRA | M_R_OUT | M_PC_EN);
`ifdef CU_MULDIV_EN
    end else if (op == 5'd15 || op == 5'd16) begin
      exp_q.push_back(M_RUN | M_GRA | M_R_OUT | M_Y_EN);
      exp_q.push_back(M_RUN | M_GRB | M_R_OUT | M_Z_EN | opw(op));
      exp_q.push_back(M_RUN | M_ZLOW | M_LO_EN);
      exp_q.push_back(M_RUN | M_ZHIGH | M_HI_EN);
`endif
    end else if (op == 5'd27) begin
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Hold clr for two edges, then check the RESET word while clr is high and after release
  task automatic do_reset();
    clr = 1'b1;
    stop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("reset_held", observed(), M_RUN);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check_eq("reset_state", observed(), M_RUN);
  endtask

  // Expect the halted word for a number of clocks, then recover through clr
  task automatic check_halted(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1 stop = 1'b0;
      @(negedge clk);
      check_eq($sformatf("halted_%0d", k), observed(), 32'd0);
    end
    do_reset();
  endtask

  // Run one instruction from T0; optionally abort with clr at abort_at,
  // optionally raise stop on the last step.
  task automatic exec_instr(input logic [31:0] ir, input logic con, input logic stp,
                            input int abort_at);
    int          n;
    bit          halts;
    logic [31:0] w;
    exp_q.delete();
    halts = model_instr(ir, con);
    n = exp_q.size();
    @(posedge clk);
    #1;
    IR = ir;
    CON = con;
    stop = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      w = exp_q.pop_front();
      check_eq($sformatf("op%0d_step%0d", ir[31:27], i), observed(), w);
      if (i == abort_at) begin
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check_eq("abort_reset", observed(), M_RUN);
        return;
      end
      if (i == n - 1) stop = stp;
    end
    if (halts || stp) check_halted(10);
  endtask

  // Stimulus
  initial begin
    logic [4:0]  rop;
    logic [31:0] rir;
    int          sel;
    clr = 1'b1;
    IR = 32'hD0000000;
    CON = 1'b0;
    stop = 1'b0;

    // Reset then a few nops
    do_reset();
    for (int i = 0; i < 3; i++) exec_instr(32'hD0000000, 1'b0, 1'b0, -1);
    // add R5,R3,R0
    exec_instr(32'h1A980000, 1'b0, 1'b0, -1);
    // brzr with C=25, taken and not taken
    exec_instr(32'h98000019, 1'b1, 1'b0, -1);
    exec_instr(32'h98000019, 1'b0, 1'b0, -1);
    // st, ld, ldi, immediates, jr
    exec_instr(32'h10800040, 1'b0, 1'b0, -1);
    exec_instr(32'h00800040, 1'b0, 1'b0, -1);
    exec_instr(32'h08800005, 1'b0, 1'b0, -1);
    exec_instr(32'h60880007, 1'b0, 1'b0, -1);
    exec_instr(32'h68880007, 1'b0, 1'b0, -1);
    exec_instr(32'h70880007, 1'b0, 1'b0, -1);
    exec_instr(32'hA0800000, 1'b0, 1'b0, -1);
    // mul/div opcodes
    exec_instr(32'h78000000, 1'b0, 1'b0, -1);
    exec_instr(32'h80000000, 1'b0, 1'b0, -1);
    // clr during T5 of a ld, then normal fetch again
    exec_instr(32'h00800040, 1'b0, 1'b0, 5);
    exec_instr(32'h1A980000, 1'b0, 1'b0, -1);
    // halt instruction, then stop on the last step of an add
    exec_instr(32'hD8000000, 1'b0, 1'b0, -1);
    exec_instr(32'h1A980000, 1'b0, 1'b1, -1);
    exec_instr(32'h1A980000, 1'b0, 1'b0, -1);

    // Randomized instruction stream
    for (int t = 0; t < 80; t++) begin
      rop = 5'($urandom_range(0, 31));
      rir = {rop, 27'($urandom)};
      sel = $urandom_range(0, 9);
      if (sel == 0)
        exec_instr(rir, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3));
      else
        exec_instr(rir, 1'($urandom_range(0, 1)), (sel == 1), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
